instr_fetch_ctl: RTL

//  Sequences the PC into the byte-addressed instruction memory. Buffers fetched

---
 rtl/instr_fetch_ctl_if.sv | 29 ++
 rtl/instr_fetch_ctl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctl_if.sv
// Fetch-controller bus bundle: instruction-memory request/response, decode
// handshake and execute redirect. master = fetch controller, slave = its environment.
interface instr_fetch_ctl_if #(
  parameter int XLEN = 32
);
  logic            en;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            id_valid;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  logic            id_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            fetch_fault;

  modport master (
    input  en, imem_gnt, imem_rvalid, imem_rdata, id_ready, redirect_valid, redirect_pc,
    output imem_req, imem_addr, id_valid, id_instr, id_pc, fetch_fault
  );

  modport slave (
    output en, imem_gnt, imem_rvalid, imem_rdata, id_ready, redirect_valid, redirect_pc,
    input  imem_req, imem_addr, id_valid, id_instr, id_pc, fetch_fault
  );
endinterface

// File: rtl/instr_fetch_ctl.sv
// Instruction fetch controller: PC sequencing, in-order fetch queue, redirect flush.
// Optional macro IF_MISALIGN_CHECK_EN: misaligned redirect raises fetch_fault and halts.
module instr_fetch_ctl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              QDEPTH   = 2
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_ctl_if.master  bus
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
`ifdef IF_MISALIGN_CHECK_EN
  localparam logic [1:0] S_HALT  = 2'd2;
`endif

  logic [XLEN-1:0] pc_q, pc_d;
  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   qrd_q, qrd_d, qwr_q, qwr_d;
  logic [PW-1:0]   frd_q, frd_d, fwr_q, fwr_d;
  logic [31:0]     q_instr_q [QDEPTH];
  logic [31:0]     q_instr_d [QDEPTH];
  logic [XLEN-1:0] q_pc_q    [QDEPTH];
  logic [XLEN-1:0] q_pc_d    [QDEPTH];
  logic [XLEN-1:0] fl_pc_q   [QDEPTH];
  logic [XLEN-1:0] fl_pc_d   [QDEPTH];
`ifdef IF_MISALIGN_CHECK_EN
  logic            fault_q, fault_d;
  logic            redir_misaligned;
`endif

  logic [CW:0]     occ;
  logic            issue_ok, issue, rsp_ok, id_valid_c, pop;
  logic [XLEN-1:0] redir_pc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Queued plus outstanding entries are capped so every response has a slot.
  assign occ        = {1'b0, count_q} + {1'b0, outst_q};
  assign issue_ok   = bus.en && (state_q == S_RUN) && !bus.redirect_valid &&
                      (occ < (CW + 1)'(QDEPTH));
  assign issue      = issue_ok && bus.imem_gnt;
  assign rsp_ok     = bus.imem_rvalid && (outst_q != '0);
  assign id_valid_c = (count_q != '0) && !bus.redirect_valid;
  assign pop        = id_valid_c && bus.id_ready;
  assign redir_pc   = bus.redirect_pc & ~XLEN'(3);
`ifdef IF_MISALIGN_CHECK_EN
  assign redir_misaligned = bus.redirect_pc[1:0] != 2'b00;
`endif

  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    outst_d    = outst_q;
    drop_cnt_d = drop_cnt_q;
    count_d    = count_q;
    qrd_d      = qrd_q;
    qwr_d      = qwr_q;
    frd_d      = frd_q;
    fwr_d      = fwr_q;
    q_instr_d  = q_instr_q;
    q_pc_d     = q_pc_q;
    fl_pc_d    = fl_pc_q;
`ifdef IF_MISALIGN_CHECK_EN
    fault_d    = fault_q;
`endif
    case (state_q)
      S_RUN: begin
        if (bus.redirect_valid) begin
          // A response landing with the redirect is already stale.
          count_d    = '0;
          qrd_d      = '0;
          qwr_d      = '0;
          frd_d      = '0;
          fwr_d      = '0;
          pc_d       = redir_pc;
          outst_d    = outst_q - CW'(rsp_ok);
          drop_cnt_d = outst_d;
          state_d    = (outst_d != '0) ? S_FLUSH : S_RUN;
`ifdef IF_MISALIGN_CHECK_EN
          if (redir_misaligned) begin
            state_d = S_HALT;
            fault_d = 1'b1;
          end
`endif
        end else begin
          if (issue) begin
            fl_pc_d[fwr_q] = pc_q;
            fwr_d          = ptr_inc(fwr_q);
            pc_d           = pc_q + XLEN'(4);
          end
          if (rsp_ok) begin
            q_pc_d[qwr_q]    = fl_pc_q[frd_q];
            q_instr_d[qwr_q] = bus.imem_rdata;
            qwr_d            = ptr_inc(qwr_q);
            frd_d            = ptr_inc(frd_q);
          end
          if (pop) qrd_d = ptr_inc(qrd_q);
          count_d = count_q + CW'(rsp_ok) - CW'(pop);
          outst_d = outst_q + CW'(issue) - CW'(rsp_ok);
        end
      end
      S_FLUSH: begin
        if (rsp_ok) begin
          outst_d    = outst_q - 1'b1;
          drop_cnt_d = drop_cnt_q - 1'b1;
        end
        if (bus.redirect_valid) pc_d = redir_pc;
        state_d = (drop_cnt_d == '0) ? S_RUN : S_FLUSH;
`ifdef IF_MISALIGN_CHECK_EN
        if (bus.redirect_valid && redir_misaligned) begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end
`endif
      end
`ifdef IF_MISALIGN_CHECK_EN
      S_HALT: begin
        if (rsp_ok) begin
          outst_d    = outst_q - 1'b1;
          drop_cnt_d = (drop_cnt_q != '0) ? drop_cnt_q - 1'b1 : '0;
        end
      end
`endif
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      state_q    <= S_RUN;
      outst_q    <= '0;
      drop_cnt_q <= '0;
      count_q    <= '0;
      qrd_q      <= '0;
      qwr_q      <= '0;
      frd_q      <= '0;
      fwr_q      <= '0;
`ifdef IF_MISALIGN_CHECK_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      pc_q       <= pc_d;
      state_q    <= state_d;
      outst_q    <= outst_d;
      drop_cnt_q <= drop_cnt_d;
      count_q    <= count_d;
      qrd_q      <= qrd_d;
      qwr_q      <= qwr_d;
      frd_q      <= frd_d;
      fwr_q      <= fwr_d;
`ifdef IF_MISALIGN_CHECK_EN
      fault_q    <= fault_d;
`endif
    end
    q_instr_q <= q_instr_d;
    q_pc_q    <= q_pc_d;
    fl_pc_q   <= fl_pc_d;
  end

  // Storage is not reset; the head is forced to zero whenever the queue is empty.
  assign bus.imem_req  = issue_ok;
  assign bus.imem_addr = pc_q;
  assign bus.id_valid  = id_valid_c;
  assign bus.id_instr  = (count_q != '0) ? q_instr_q[qrd_q] : '0;
  assign bus.id_pc     = (count_q != '0) ? q_pc_q[qrd_q] : '0;
`ifdef IF_MISALIGN_CHECK_EN
  assign bus.fetch_fault = fault_q;
`else
  assign bus.fetch_fault = 1'b0;
`endif

  a_rvalid_has_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n) bus.imem_rvalid |-> (outst_q != '0));

endmodule
